clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter COUNTER_BITS, default 32, width of the divider value (valid range 8..32).
REQ-002 Parameter STEP_GAP, default 4, idle cycles between consecutive step pulses (>=1).
REQ-003 clk  in  1  single clock; all state on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rx_data / rx_valid / rx_ready  in/in/out  8/1/1  command byte stream; a byte transfers when valid&ready.
REQ-006 tx_data / tx_valid / tx_ready  out/out/in  8/1/1  response byte stream; same handshake.
REQ-007 option / out_enable / pulse  out  1 each  divider mode, divider output enable, single-cycle step strobe.
REQ-008 divider  out  COUNTER_BITS  divider value driven to the clock divider.
REQ-009 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-010 FSM states: IDLE, PAYLOAD, EXEC, STEP, RESP; rx_ready SHALL be high only in IDLE and PAYLOAD.
REQ-011 Opcodes: 0x01 SET_DIV (+4 bytes, little-endian), 0x02 ENABLE, 0x03 DISABLE, 0x04 MODE (+1 byte, bit0 -> option), 0x05 STEP (+2 bytes LE count), 0x06 STATUS.
REQ-012 IDLE: accepted known opcode with payload -> PAYLOAD; without payload -> EXEC; unknown opcode -> RESP with 0xEE.
REQ-013 PAYLOAD: bytes shifted into a 32-bit staging register; after last byte -> EXEC next cycle.
REQ-014 divider SHALL update atomically in EXEC only; staging bits above COUNTER_BITS discarded.
REQ-015 Partial SET_DIV payload SHALL leave divider unchanged.
REQ-016 ENABLE/DISABLE set/clear out_enable in EXEC; MODE writes option in EXEC.
REQ-017 STEP count 0 SHALL produce no pulses; count N SHALL produce exactly N one-cycle pulses, STEP_GAP low cycles between them, first pulse the cycle after EXEC.
REQ-018 Every successful command SHALL return one byte 0xA0|opcode in RESP; STATUS returns {5'b0, pulse_active, option, out_enable} instead.
REQ-019 RESP holds tx_valid and tx_data stable until tx_ready; then -> IDLE.
REQ-020 Latency: no-payload command accepted in cycle T -> tx_valid at T+2 (T+1 EXEC, T+2 RESP).
REQ-021 rx bytes arriving while busy outside PAYLOAD SHALL be back-pressured, never dropped.

Reset
REQ-022 Reset asserted SHALL immediately force: state IDLE, option 0, out_enable 0, pulse 0, divider 0, tx_valid 0, busy 0, staging and step counters 0.
REQ-023 Reset mid-STEP or mid-PAYLOAD SHALL abort without emitting further pulses or responses.

Configuration
REQ-024 Macro CLK_DIV_CTRL_STEP_EN compiles in the STEP opcode and STEP state.
REQ-025 Without CLK_DIV_CTRL_STEP_EN: pulse tied 0, opcode 0x05 treated as unknown (response 0xEE, no payload consumed).

Structure
REQ-026 Opcodes, response codes (0xA0 base, 0xEE) and state encoding SHALL live in shared package clk_div_ctrl_pkg.
REQ-027 Step generation SHALL be sub-module step_pulse_gen (count, gap counter, done flag).

Verification
REQ-028 Send 01 10 27 00 00 -> divider 0x00002710 after EXEC, response 0xA1; divider unchanged during payload.
REQ-029 Send 02 then 06 -> out_enable 1, responses 0xA2 then 0x01.
REQ-030 Send 05 03 00 (STEP_GAP=4) -> exactly 3 pulses spaced 5 cycles, then 0xA5; with 05 00 00 -> zero pulses, 0xA5.
REQ-031 Send 0x7F -> response 0xEE, no output change; hold tx_ready low 10 cycles -> tx_data/tx_valid stable, rx_ready low.
REQ-032 Assert reset after 2 payload bytes of SET_DIV and mid-STEP -> all outputs 0, no tx_valid, next command 03 -> 0xA3.
REQ-033 Build without CLK_DIV_CTRL_STEP_EN: send 05 -> 0xEE, next byte decoded as new opcode, pulse never high.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared opcodes, response codes and FSM encoding for clk_div_ctrl.
// The STEP opcode is decoded only when CLK_DIV_CTRL_STEP_EN is defined.
package clk_div_ctrl_pkg;

  localparam logic [7:0] OpSetDiv  = 8'h01;
  localparam logic [7:0] OpEnable  = 8'h02;
  localparam logic [7:0] OpDisable = 8'h03;
  localparam logic [7:0] OpMode    = 8'h04;
  localparam logic [7:0] OpStep    = 8'h05;
  localparam logic [7:0] OpStatus  = 8'h06;

  localparam logic [7:0] RespBase  = 8'hA0;
  localparam logic [7:0] RespErr   = 8'hEE;

  localparam int unsigned StepCountBits = 16;

  typedef enum logic [2:0] {
    StIdle,
    StPayload,
    StExec,
    StStep,
    StResp
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
    logic known;
    case (op)
      OpSetDiv, OpEnable, OpDisable, OpMode, OpStatus: known = 1'b1;
`ifdef CLK_DIV_CTRL_STEP_EN
      OpStep: known = 1'b1;
`endif
      default: known = 1'b0;
    endcase
    return known;
  endfunction

  function automatic logic [2:0] op_payload_len(input logic [7:0] op);
    logic [2:0] len;
    case (op)
      OpSetDiv: len = 3'd4;
      OpMode:   len = 3'd1;
`ifdef CLK_DIV_CTRL_STEP_EN
      OpStep:   len = 3'd2;
`endif
      default:  len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_step_pulse_gen.sv
// Emits `count` single-cycle pulses separated by STEP_GAP low cycles; the first
// pulse appears the cycle after `start`.
module step_pulse_gen #(
  parameter int unsigned STEP_GAP   = 4,
  parameter int unsigned COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COUNT_BITS-1:0] count,
  output logic                  pulse,
  output logic                  active,
  output logic                  done
);

  localparam int unsigned GapBits = $clog2(STEP_GAP + 1);
  localparam logic [GapBits-1:0] GapLoad = GapBits'(STEP_GAP);

  logic [COUNT_BITS-1:0] remain_q;
  logic [GapBits-1:0]    gap_q;
  logic                  pulse_q;
  logic                  active_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remain_q <= '0;
      gap_q    <= '0;
      pulse_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (start) begin
        if (count != '0) begin
          pulse_q  <= 1'b1;
          remain_q <= count - COUNT_BITS'(1);
          gap_q    <= GapLoad;
          active_q <= 1'b1;
        end else begin
          remain_q <= '0;
          gap_q    <= '0;
          active_q <= 1'b0;
        end
      end else if (active_q) begin
        // Gap after the final pulse is also counted out before reporting done.
        if (gap_q != '0) begin
          gap_q <= gap_q - GapBits'(1);
        end else if (remain_q != '0) begin
          pulse_q  <= 1'b1;
          remain_q <= remain_q - COUNT_BITS'(1);
          gap_q    <= GapLoad;
        end else begin
          active_q <= 1'b0;
        end
      end
    end
  end

  assign pulse  = pulse_q;
  assign active = active_q;
  assign done   = !active_q && !start;

endmodule

// File: rtl/clk_div_ctrl.sv
// Byte-command controller for a clock divider: decodes commands, applies them in
// EXEC and returns one response byte. STEP support requires CLK_DIV_CTRL_STEP_EN.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned COUNTER_BITS = 32,
  parameter int unsigned STEP_GAP     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    option,
  output logic                    out_enable,
  output logic                    pulse,
  output logic [COUNTER_BITS-1:0] divider,
  output logic                    busy
);

  state_e                  state_q;
  logic [7:0]              op_q;
  logic [31:0]             stage_q;
  logic [2:0]              byte_idx_q;
  logic [2:0]              need_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic                    option_q;
  logic                    out_enable_q;
  logic [COUNTER_BITS-1:0] divider_q;

  logic pulse_active;
  logic step_done;

`ifdef CLK_DIV_CTRL_STEP_EN
  logic step_start;
  assign step_start = (state_q == StExec) && (op_q == OpStep);

  step_pulse_gen #(
    .STEP_GAP   (STEP_GAP),
    .COUNT_BITS (StepCountBits)
  ) u_step (
    .clk    (clk),
    .reset  (reset),
    .start  (step_start),
    .count  (stage_q[StepCountBits-1:0]),
    .pulse  (pulse),
    .active (pulse_active),
    .done   (step_done)
  );
`else
  assign pulse        = 1'b0;
  assign pulse_active = 1'b0;
  assign step_done    = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      op_q         <= '0;
      stage_q      <= '0;
      byte_idx_q   <= '0;
      need_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      option_q     <= 1'b0;
      out_enable_q <= 1'b0;
      divider_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            op_q       <= rx_data;
            stage_q    <= '0;
            byte_idx_q <= '0;
            if (!op_known(rx_data)) begin
              tx_data_q  <= RespErr;
              tx_valid_q <= 1'b1;
              state_q    <= StResp;
            end else if (op_payload_len(rx_data) != 3'd0) begin
              need_q  <= op_payload_len(rx_data);
              state_q <= StPayload;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StPayload: begin
          if (rx_valid) begin
            // Little-endian: byte n lands in bits [8n+7:8n].
            stage_q[{byte_idx_q[1:0], 3'b000} +: 8] <= rx_data;
            byte_idx_q <= byte_idx_q + 3'd1;
            if (byte_idx_q + 3'd1 == need_q) begin
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          tx_data_q  <= RespBase | op_q;
          tx_valid_q <= 1'b1;
          state_q    <= StResp;
          case (op_q)
            OpSetDiv:  divider_q    <= stage_q[COUNTER_BITS-1:0];
            OpEnable:  out_enable_q <= 1'b1;
            OpDisable: out_enable_q <= 1'b0;
            OpMode:    option_q     <= stage_q[0];
            OpStatus:  tx_data_q    <= {5'b0, pulse_active, option_q, out_enable_q};
`ifdef CLK_DIV_CTRL_STEP_EN
            OpStep: begin
              tx_valid_q <= 1'b0;
              state_q    <= StStep;
            end
`endif
            default: ;
          endcase
        end
`ifdef CLK_DIV_CTRL_STEP_EN
        StStep: begin
          if (step_done) begin
            tx_data_q  <= RespBase | OpStep;
            tx_valid_q <= 1'b1;
            state_q    <= StResp;
          end
        end
`endif
        StResp: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_ready   = (state_q == StIdle) || (state_q == StPayload);
  assign busy       = (state_q != StIdle);
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign option     = option_q;
  assign out_enable = out_enable_q;
  assign divider    = divider_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed plus randomized command bench for clk_div_ctrl against a behavioural model.
// STEP expectations follow CLK_DIV_CTRL_STEP_EN.
module tb_clk_div_ctrl;

  localparam int unsigned CB  = 32;
  localparam int unsigned GAP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          option;
  logic          out_enable;
  logic          pulse;
  logic [CB-1:0] divider;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;

  // Behavioural model of the externally visible configuration.
  logic [CB-1:0] m_div = '0;
  logic          m_en  = 1'b0;
  logic          m_opt = 1'b0;

  clk_div_ctrl #(
    .COUNTER_BITS (CB),
    .STEP_GAP     (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .option     (option),
    .out_enable (out_enable),
    .pulse      (pulse),
    .divider    (divider),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pulse === 1'b1) pulse_total++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic get_resp(output logic [7:0] d);
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tx_valid_timeout", 32'(n < 300), 32'd1);
    d = tx_data;
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_divider"}, divider, m_div);
    check({tag, "_out_enable"}, 32'(out_enable), 32'(m_en));
    check({tag, "_option"}, 32'(option), 32'(m_opt));
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b0;
    #1;
    check("rst_divider", divider, 0);
    check("rst_flags", {27'b0, out_enable, option, pulse, tx_valid, busy}, 0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    m_div = '0;
    m_en  = 1'b0;
    m_opt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef CLK_DIV_CTRL_STEP_EN
  // Called in the EXEC cycle; records pulse cycle offsets until the response appears.
  task automatic collect_step(input int n_exp);
    int q[$];
    int k;
    int bad;
    k = 0;
    bad = 0;
    while (tx_valid !== 1'b1 && k < 300) begin
      @(negedge clk);
      if (pulse === 1'b1) q.push_back(k);
      k++;
    end
    check("step_pulse_count", q.size(), n_exp);
    if (q.size() > 0) check("step_first_pulse", q[0], 1);
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != int'(GAP + 1)) bad++;
    check("step_spacing", bad, 0);
  endtask
`endif

  initial begin
    logic [7:0] d;
    logic [7:0] op;
    logic [7:0] b [4];
    int         snap;
    int         bad;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_divider", divider, 0);
    check("rst_flags", {27'b0, out_enable, option, pulse, tx_valid, busy}, 0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // SET_DIV: divider holds during payload and in EXEC, then updates
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h27);
    send_byte(8'h00);
    check("setdiv_payload_hold", divider, 0);
    check("setdiv_busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    check("setdiv_exec_hold", divider, 0);
    get_resp(d);
    check("setdiv_resp", d, 8'hA1);
    m_div = 32'h0000_2710;
    check_model("setdiv");

    // ENABLE latency then STATUS
    send_byte(8'h02);
    check("enable_lat_t1", 32'(tx_valid), 32'd0);
    @(posedge clk);
    #1;
    check("enable_lat_t2", 32'(tx_valid), 32'd1);
    get_resp(d);
    check("enable_resp", d, 8'hA2);
    m_en = 1'b1;
    send_byte(8'h06);
    get_resp(d);
    check("status_resp", d, {5'b0, 1'b0, m_opt, m_en});
    check_model("enable");

`ifdef CLK_DIV_CTRL_STEP_EN
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    collect_step(3);
    get_resp(d);
    check("step3_resp", d, 8'hA5);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    collect_step(0);
    get_resp(d);
    check("step0_resp", d, 8'hA5);
`else
    send_byte(8'h05);
    get_resp(d);
    check("nostep_resp", d, 8'hEE);
    send_byte(8'h03);
    get_resp(d);
    check("nostep_next_op", d, 8'hA3);
    m_en = 1'b0;
    check_model("nostep");
`endif

    // Unknown opcode; hold the response while a new byte waits
    send_byte(8'h7F);
    while (tx_valid !== 1'b1) @(negedge clk);
    d = tx_data;
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== d || rx_ready !== 1'b0) bad++;
    end
    check("unknown_resp", d, 8'hEE);
    check("hold_stable", bad, 0);
    check_model("unknown");
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    get_resp(d);
    check("backpressure_resp", d, 8'hA2);
    m_en = 1'b1;
    check_model("backpressure");

    // Reset mid-PAYLOAD
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h66);
    do_reset();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) bad++;
    end
    check("rst_payload_no_tx", bad, 0);
    check_model("rst_payload");

`ifdef CLK_DIV_CTRL_STEP_EN
    // Reset mid-STEP
    snap = pulse_total;
    send_byte(8'h05); send_byte(8'h0A); send_byte(8'h00);
    bad = 0;
    while (pulse_total < snap + 2 && bad < 200) begin
      @(negedge clk);
      bad++;
    end
    check("rst_step_started", 32'(pulse_total >= snap + 2), 32'd1);
    @(posedge clk);
    do_reset();
    snap = pulse_total;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) bad++;
    end
    check("rst_step_no_tx", bad, 0);
    check("rst_step_no_pulse", pulse_total, snap);
`endif
    @(posedge clk);
    #1;
    send_byte(8'h03);
    get_resp(d);
    check("post_reset_disable", d, 8'hA3);
    check_model("post_reset");

    // Randomized command stream
    for (int it = 0; it < 30; it++) begin
      logic [7:0]  exp;
      logic [31:0] val;
      int          cnt;
      int          sel;
      sel = int'($urandom_range(0, 6));
      op = (sel == 0) ? 8'($urandom_range(7, 255)) : 8'(sel);
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      exp = 8'hA0 | op;
      send_byte(op);
      case (op)
        8'h01: begin
          for (int i = 0; i < 4; i++) send_byte(b[i]);
          val = {b[3], b[2], b[1], b[0]};
          m_div = val[CB-1:0];
        end
        8'h02: m_en = 1'b1;
        8'h03: m_en = 1'b0;
        8'h04: begin
          send_byte(b[0]);
          m_opt = b[0][0];
        end
        8'h05: begin
`ifdef CLK_DIV_CTRL_STEP_EN
          cnt = int'($urandom_range(0, 3));
          send_byte(8'(cnt));
          send_byte(8'h00);
          collect_step(cnt);
`else
          exp = 8'hEE;
`endif
        end
        8'h06: exp = {5'b0, 1'b0, m_opt, m_en};
        default: exp = 8'hEE;
      endcase
      get_resp(d);
      check($sformatf("rand_resp_%0d_op%0h", it, op), d, exp);
      check_model($sformatf("rand_%0d", it));
    end

`ifndef CLK_DIV_CTRL_STEP_EN
    check("nostep_pulse_never", pulse_total, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
